// File: rtl/xadc_drp_sequencer_pkg.sv
// Shared types and constants for the XADC DRP read sequencer.
`timescale 1ns/1ps
package xadc_drp_package;

    localparam int XADC_DRP_DATA_WIDTH = 16;

    typedef logic [6:0] xadc_drp_addr_t;

    // Default result registers read by a sweep.
    localparam xadc_drp_addr_t VAUX4  = 7'h14;
    localparam xadc_drp_addr_t VAUX12 = 7'h1C;

    // Value stored in a result slot whose DRP read never completed.
    localparam logic [XADC_DRP_DATA_WIDTH-1:0] XADC_DRP_TIMEOUT_FILL = 16'hFFFF;

    typedef enum logic [1:0] {
        SEQ_IDLE   = 2'd0,
        SEQ_ISSUE  = 2'd1,
        SEQ_WAIT   = 2'd2,
        SEQ_OUTPUT = 2'd3
    } seq_state_t;

endpackage

// File: rtl/xadc_drp_sequencer_if.sv
// DRP read port and AXI-Stream output bundle of the sequencer.
// Stream handshake: a beat transfers in any cycle where m_axis_tvalid and
// m_axis_tready are both high; once raised, tvalid and tdata/tlast hold
// steady until that transfer cycle.
`timescale 1ns/1ps
interface xadc_drp_sequencer_if #(
    parameter int OUT_W = 32
);
    import xadc_drp_package::*;

    xadc_drp_addr_t                 xadc_daddr;
    logic                           xadc_den;
    logic                           xadc_drdy;
    logic [XADC_DRP_DATA_WIDTH-1:0] xadc_do;
    logic [OUT_W-1:0]               m_axis_tdata;
    logic                           m_axis_tvalid;
    logic                           m_axis_tready;
    logic                           m_axis_tlast;

    modport master (
        output xadc_daddr, xadc_den, m_axis_tdata, m_axis_tvalid, m_axis_tlast,
        input  xadc_drdy, xadc_do, m_axis_tready
    );

    modport slave (
        input  xadc_daddr, xadc_den, m_axis_tdata, m_axis_tvalid, m_axis_tlast,
        output xadc_drdy, xadc_do, m_axis_tready
    );

endinterface

// File: rtl/xadc_drp_sequencer_decimator.sv
// Divides XADC end-of-sequence pulses down to sweep triggers.
`timescale 1ns/1ps
module xadc_eos_decimator #(
    parameter int DECIM_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic [DECIM_WIDTH-1:0] decimation,
    input  logic                   eos,
    output logic                   trigger
);

    logic [DECIM_WIDTH-1:0] count_q;
    logic [DECIM_WIDTH-1:0] last_count;

    // A decimation of 0 behaves like 1. The >= compare means a decimation
    // lowered below the running count fires on the next eos instead of
    // wrapping the counter.
    assign last_count = (decimation == '0) ? '0 : decimation - DECIM_WIDTH'(1);
    assign trigger    = enable && eos && (count_q >= last_count);

    // Count eos pulses while enabled; restart after each trigger.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (!enable) begin
            count_q <= '0;
        end else if (eos) begin
            count_q <= trigger ? '0 : count_q + DECIM_WIDTH'(1);
        end
    end

endmodule

// File: rtl/xadc_drp_sequencer.sv
// Reads a fixed list of XADC result registers over DRP every Nth
// end-of-sequence and emits them as a single AXI-Stream beat.
// Optional: define XADC_DRP_SEQ_TIMESTAMP_EN to append a 32-bit cycle
// timestamp, captured at the trigger, in the top 32 bits of tdata.
`timescale 1ns/1ps
module xadc_drp_sequencer
    import xadc_drp_package::*;
#(
    parameter int                      NUM_CHANNELS   = 2,
    parameter logic [NUM_CHANNELS*7-1:0] CHANNEL_ADDRS = {VAUX12, VAUX4},
    parameter int                      TIMEOUT_CYCLES = 64,
    parameter int                      DECIM_WIDTH    = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic [DECIM_WIDTH-1:0] decimation,
    input  logic                   xadc_eos,
    xadc_drp_sequencer_if.master   bus,
    output logic                   busy,
    output logic [15:0]            overrun_count,
    output logic                   timeout_err
);

    localparam int RES_W = NUM_CHANNELS * XADC_DRP_DATA_WIDTH;
    localparam int IDX_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES);

    seq_state_t         state_q, state_d;
    logic [IDX_W-1:0]   idx_q;
    logic [TMR_W-1:0]   timer_q;
    logic [RES_W-1:0]   result_q;
    xadc_drp_addr_t     daddr_q;
    logic [15:0]        overrun_q;
    logic               timeout_err_q;
    logic               trigger;
    logic               last_slot;
    logic               timed_out;
    logic               sweep_start;
    logic               advance;

    xadc_eos_decimator #(
        .DECIM_WIDTH (DECIM_WIDTH)
    ) u_decimator (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .decimation (decimation),
        .eos        (xadc_eos),
        .trigger    (trigger)
    );

    assign last_slot = (idx_q == IDX_W'(NUM_CHANNELS - 1));
    assign timed_out = (timer_q == TMR_W'(TIMEOUT_CYCLES - 1));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SEQ_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; drdy in the timeout cycle counts as a normal read.
    always_comb begin
        state_d     = state_q;
        sweep_start = 1'b0;
        advance     = 1'b0;
        case (state_q)
            SEQ_IDLE: begin
                if (trigger) begin
                    state_d     = SEQ_ISSUE;
                    sweep_start = 1'b1;
                end
            end
            SEQ_ISSUE: state_d = SEQ_WAIT;
            SEQ_WAIT: begin
                if (bus.xadc_drdy || timed_out) begin
                    advance = 1'b1;
                    state_d = last_slot ? SEQ_OUTPUT : SEQ_ISSUE;
                end
            end
            SEQ_OUTPUT: begin
                if (bus.m_axis_tready) begin
                    state_d = SEQ_IDLE;
                end
            end
            default: state_d = SEQ_IDLE;
        endcase
    end

    // Slot index and DRP address, loaded on entry to each ISSUE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q   <= '0;
            daddr_q <= '0;
        end else if (sweep_start) begin
            idx_q   <= '0;
            daddr_q <= CHANNEL_ADDRS[6:0];
        end else if (advance && !last_slot) begin
            idx_q   <= idx_q + IDX_W'(1);
            daddr_q <= CHANNEL_ADDRS[7*(int'(idx_q) + 1) +: 7];
        end
    end

    // drdy timeout timer: cleared in ISSUE, counts while waiting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_q <= '0;
        end else if (state_q == SEQ_ISSUE) begin
            timer_q <= '0;
        end else if (state_q == SEQ_WAIT && !timed_out) begin
            timer_q <= timer_q + TMR_W'(1);
        end
    end

    // Result slots and the sticky timeout flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q      <= '0;
            timeout_err_q <= 1'b0;
        end else if (advance) begin
            result_q[XADC_DRP_DATA_WIDTH*int'(idx_q) +: XADC_DRP_DATA_WIDTH] <=
                bus.xadc_drdy ? bus.xadc_do : XADC_DRP_TIMEOUT_FILL;
            if (!bus.xadc_drdy) begin
                timeout_err_q <= 1'b1;
            end
        end
    end

    // Saturating count of triggers that arrive while a sweep is in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun_q <= '0;
        end else if (trigger && state_q != SEQ_IDLE && overrun_q != 16'hFFFF) begin
            overrun_q <= overrun_q + 16'd1;
        end
    end

`ifdef XADC_DRP_SEQ_TIMESTAMP_EN
    logic [31:0] cycle_q;
    logic [31:0] stamp_q;

    // Free-running cycle counter, sampled when a sweep is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_q <= '0;
            stamp_q <= '0;
        end else begin
            cycle_q <= cycle_q + 32'd1;
            if (sweep_start) begin
                stamp_q <= cycle_q;
            end
        end
    end

    assign bus.m_axis_tdata = {stamp_q, result_q};
`else
    assign bus.m_axis_tdata = result_q;
`endif

    assign bus.xadc_daddr    = daddr_q;
    assign bus.xadc_den      = (state_q == SEQ_ISSUE);
    assign bus.m_axis_tvalid = (state_q == SEQ_OUTPUT);
    assign bus.m_axis_tlast  = (state_q == SEQ_OUTPUT);
    assign busy              = (state_q != SEQ_IDLE);
    assign overrun_count     = overrun_q;
    assign timeout_err       = timeout_err_q;

endmodule

// File: tb/tb_xadc_drp_sequencer.sv
// Directed bench for xadc_drp_sequencer with a DRP responder and a stream
// monitor. Covers XADC_DRP_SEQ_TIMESTAMP_EN when that macro is defined.
`timescale 1ns/1ps
module tb_xadc_drp_sequencer;
    import xadc_drp_package::*;

    localparam int RES_W = 32;
`ifdef XADC_DRP_SEQ_TIMESTAMP_EN
    localparam int OUT_W = RES_W + 32;
`else
    localparam int OUT_W = RES_W;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [15:0] decimation;
    logic        xadc_eos;
    logic        busy;
    logic [15:0] overrun_count;
    logic        timeout_err;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    logic [OUT_W-1:0] beat_q[$];
    logic             tlast_q[$];
    logic [RES_W-1:0] exp_q[$];
    logic [6:0]       den_addr_q[$];
    int               den_cyc_q[$];
    int               rise_q[$];
    logic             prev_valid = 1'b0;

    int          resp_k    = 3;
    logic [15:0] resp_d0   = 16'h0;
    logic [15:0] resp_d1   = 16'h0;
    logic [6:0]  drop_addr = 7'h7F;

    xadc_drp_sequencer_if #(.OUT_W(OUT_W)) bus ();

    xadc_drp_sequencer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .decimation    (decimation),
        .xadc_eos      (xadc_eos),
        .bus           (bus.master),
        .busy          (busy),
        .overrun_count (overrun_count),
        .timeout_err   (timeout_err)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- DRP responder ----------------
    // Returns drdy resp_k cycles after each den, except for drop_addr.
    initial begin
        logic [6:0] a;
        bus.xadc_drdy = 1'b0;
        bus.xadc_do   = 16'h0;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && bus.xadc_den === 1'b1) begin
                a = bus.xadc_daddr;
                if (a != drop_addr) begin
                    repeat (resp_k) @(posedge clk);
                    #1;
                    bus.xadc_drdy = 1'b1;
                    bus.xadc_do   = (a == VAUX4) ? resp_d0 : resp_d1;
                    @(posedge clk);
                    #1;
                    bus.xadc_drdy = 1'b0;
                    bus.xadc_do   = 16'h0;
                end
            end
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (bus.xadc_den === 1'b1) begin
                den_addr_q.push_back(bus.xadc_daddr);
                den_cyc_q.push_back(cyc);
            end
            if (bus.m_axis_tvalid === 1'b1 && prev_valid !== 1'b1)
                rise_q.push_back(cyc);
            if (bus.m_axis_tvalid === 1'b1 && bus.m_axis_tready === 1'b1) begin
                beat_q.push_back(bus.m_axis_tdata);
                tlast_q.push_back(bus.m_axis_tlast);
            end
        end
        prev_valid <= bus.m_axis_tvalid;
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_eos(output int t);
        xadc_eos = 1'b1;
        t = cyc;
        tick();
        xadc_eos = 1'b0;
    endtask

    task automatic clear_logs();
        beat_q.delete();
        tlast_q.delete();
        exp_q.delete();
        den_addr_q.delete();
        den_cyc_q.delete();
        rise_q.delete();
    endtask

    task automatic wait_beats(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (beat_q.size() >= n && busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b0; decimation = 16'd1; xadc_eos = 1'b0;
        bus.m_axis_tready = 1'b0;
        repeat (3) tick();
        vectors++; if (bus.xadc_daddr !== 7'h0) begin miscompares++; $display("FAIL reset_daddr: got %h want 00", bus.xadc_daddr); end
        vectors++; if (bus.xadc_den !== 1'b0) begin miscompares++; $display("FAIL reset_den: got %b want 0", bus.xadc_den); end
        vectors++; if (bus.m_axis_tvalid !== 1'b0 || bus.m_axis_tlast !== 1'b0) begin miscompares++; $display("FAIL reset_tvalid: got %b/%b want 0/0", bus.m_axis_tvalid, bus.m_axis_tlast); end
        vectors++; if (bus.m_axis_tdata !== '0) begin miscompares++; $display("FAIL reset_tdata: got %h want 0", bus.m_axis_tdata); end
        vectors++; if (busy !== 1'b0 || timeout_err !== 1'b0 || overrun_count !== 16'h0) begin miscompares++; $display("FAIL reset_status: got busy=%b terr=%b ovr=%h want 0/0/0", busy, timeout_err, overrun_count); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        int t; bit ok;
        clear_logs();
        enable = 1'b1; decimation = 16'd1; bus.m_axis_tready = 1'b1;
        resp_k = 3; resp_d0 = 16'h1234; resp_d1 = 16'hABCD;
        exp_q.push_back(32'hABCD_1234);
        pulse_eos(t);
        wait_beats(1, 100, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL basic_done: got %0d beats want 1", beat_q.size()); end
        vectors++;
        if (den_addr_q.size() != 2) begin miscompares++; $display("FAIL basic_den_count: got %0d want 2", den_addr_q.size()); end
        else if (den_addr_q[0] !== VAUX4 || den_addr_q[1] !== VAUX12) begin miscompares++; $display("FAIL basic_den_addr: got %h,%h want 14,1c", den_addr_q[0], den_addr_q[1]); end
        vectors++;
        if (den_cyc_q.size() < 1 || den_cyc_q[0] - t != 1) begin miscompares++; $display("FAIL basic_den_latency: got %0d want 1", den_cyc_q.size() > 0 ? den_cyc_q[0] - t : -1); end
        vectors++;
        if (rise_q.size() != 1 || rise_q[0] - t != 9) begin miscompares++; $display("FAIL basic_tvalid_latency: got %0d want 9", rise_q.size() > 0 ? rise_q[0] - t : -1); end
        vectors++;
        if (beat_q.size() != 1) begin miscompares++; $display("FAIL basic_tdata: got %0d beats want 1", beat_q.size()); end
        else if (beat_q[0][RES_W-1:0] !== exp_q[0]) begin miscompares++; $display("FAIL basic_tdata: got %h want %h", beat_q[0][RES_W-1:0], exp_q[0]); end
        vectors++;
        if (tlast_q.size() != 1 || tlast_q[0] !== 1'b1) begin miscompares++; $display("FAIL basic_tlast: got %0d entries want one tlast=1", tlast_q.size()); end
    endtask

    task automatic test_decimation();
        int eos_t[12]; int t; int starts[$]; bit ok;
        clear_logs();
        decimation = 16'd4; resp_d0 = 16'h0A0A; resp_d1 = 16'h0B0B;
        for (int i = 0; i < 12; i++) begin
            pulse_eos(eos_t[i]);
            repeat (19) tick();
        end
        wait_beats(3, 50, ok);
        foreach (den_addr_q[i]) if (den_addr_q[i] == VAUX4) starts.push_back(den_cyc_q[i]);
        vectors++;
        if (starts.size() != 3) begin miscompares++; $display("FAIL decim4_sweeps: got %0d want 3", starts.size()); end
        else if (starts[0] != eos_t[3] + 1 || starts[1] != eos_t[7] + 1 || starts[2] != eos_t[11] + 1) begin
            miscompares++; $display("FAIL decim4_trigger_eos: got %0d,%0d,%0d want %0d,%0d,%0d", starts[0], starts[1], starts[2], eos_t[3] + 1, eos_t[7] + 1, eos_t[11] + 1);
        end
        vectors++;
        if (beat_q.size() != 3) begin miscompares++; $display("FAIL decim4_beats: got %0d want 3", beat_q.size()); end
        else if (beat_q[2][RES_W-1:0] !== 32'h0B0B_0A0A) begin miscompares++; $display("FAIL decim4_tdata: got %h want 0b0b0a0a", beat_q[2][RES_W-1:0]); end

        clear_logs();
        starts.delete();
        decimation = 16'd0;
        for (int i = 0; i < 3; i++) begin
            pulse_eos(eos_t[i]);
            repeat (19) tick();
        end
        foreach (den_addr_q[i]) if (den_addr_q[i] == VAUX4) starts.push_back(den_cyc_q[i]);
        vectors++;
        if (starts.size() != 3) begin miscompares++; $display("FAIL decim0_sweeps: got %0d want 3", starts.size()); end
        else if (starts[0] != eos_t[0] + 1 || starts[2] != eos_t[2] + 1) begin miscompares++; $display("FAIL decim0_trigger_eos: got %0d,%0d want %0d,%0d", starts[0], starts[2], eos_t[0] + 1, eos_t[2] + 1); end
        vectors++; if (overrun_count !== 16'h0) begin miscompares++; $display("FAIL decim_overrun: got %h want 0", overrun_count); end
        decimation = 16'd1;
    endtask

    task automatic test_timeout();
        int t; int den1; bit ok;
        clear_logs();
        resp_d0 = 16'h5555; drop_addr = VAUX12;
        exp_q.push_back(32'hFFFF_5555);
        pulse_eos(t);
        wait_beats(1, 200, ok);
        drop_addr = 7'h7F;
        vectors++; if (!ok) begin miscompares++; $display("FAIL timeout_done: got %0d beats want 1", beat_q.size()); end
        den1 = -1000;
        foreach (den_addr_q[i]) if (den_addr_q[i] == VAUX12) den1 = den_cyc_q[i];
        vectors++;
        if (rise_q.size() != 1 || rise_q[0] - den1 != 65) begin miscompares++; $display("FAIL timeout_latency: got %0d want 65", rise_q.size() > 0 ? rise_q[0] - den1 : -1); end
        vectors++;
        if (beat_q.size() != 1 || beat_q[0][RES_W-1:0] !== exp_q[0]) begin miscompares++; $display("FAIL timeout_tdata: got %h want %h", bus.m_axis_tdata[RES_W-1:0], exp_q[0]); end
        vectors++; if (timeout_err !== 1'b1) begin miscompares++; $display("FAIL timeout_err_set: got %b want 1", timeout_err); end

        clear_logs();
        resp_d0 = 16'h0001; resp_d1 = 16'h0002;
        pulse_eos(t);
        wait_beats(1, 50, ok);
        vectors++;
        if (beat_q.size() != 1 || beat_q[0][RES_W-1:0] !== 32'h0002_0001) begin miscompares++; $display("FAIL timeout_recover_tdata: got %h want 00020001", bus.m_axis_tdata[RES_W-1:0]); end
        vectors++; if (timeout_err !== 1'b1) begin miscompares++; $display("FAIL timeout_err_sticky: got %b want 1", timeout_err); end
    endtask

    task automatic test_overrun();
        int t; bit ok; logic [OUT_W-1:0] snap;
        clear_logs();
        bus.m_axis_tready = 1'b0;
        resp_d0 = 16'h1111; resp_d1 = 16'h2222;
        pulse_eos(t);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (bus.m_axis_tvalid === 1'b1) begin ok = 1'b1; break; end
            tick();
        end
        vectors++; if (!ok) begin miscompares++; $display("FAIL overrun_tvalid: got %b want 1", bus.m_axis_tvalid); end
        snap = bus.m_axis_tdata;
        for (int i = 0; i < 10; i++) begin
            pulse_eos(t);
            repeat (2) tick();
        end
        vectors++; if (overrun_count !== 16'd10) begin miscompares++; $display("FAIL overrun_count10: got %0d want 10", overrun_count); end
        vectors++;
        if (bus.m_axis_tdata[RES_W-1:0] !== 32'h2222_1111 || bus.m_axis_tdata !== snap || bus.m_axis_tvalid !== 1'b1) begin
            miscompares++; $display("FAIL overrun_stall_data: got %h valid %b want 22221111 valid 1", bus.m_axis_tdata[RES_W-1:0], bus.m_axis_tvalid);
        end
        vectors++; if (den_addr_q.size() != 2) begin miscompares++; $display("FAIL overrun_no_new_sweep: got %0d den want 2", den_addr_q.size()); end
        // Release tready in the same cycle as an eos.
        bus.m_axis_tready = 1'b1;
        pulse_eos(t);
        wait_beats(1, 20, ok);
        vectors++; if (!ok || busy !== 1'b0) begin miscompares++; $display("FAIL overrun_release: got busy=%b beats=%0d want 0/1", busy, beat_q.size()); end
        vectors++; if (overrun_count !== 16'd11) begin miscompares++; $display("FAIL overrun_same_cycle: got %0d want 11", overrun_count); end
        vectors++;
        if (beat_q.size() != 1 || beat_q[0][RES_W-1:0] !== 32'h2222_1111) begin miscompares++; $display("FAIL overrun_beat: got %0d beats want one 22221111", beat_q.size()); end
    endtask

    task automatic test_reset_mid_sweep();
        int t; bit ok;
        clear_logs();
        resp_k = 20; resp_d0 = 16'h3333; resp_d1 = 16'h4444;
        pulse_eos(t);
        repeat (2) tick();
        rst_n = 1'b0;
        #1;
        vectors++; if (busy !== 1'b0 || bus.xadc_den !== 1'b0 || bus.xadc_daddr !== 7'h0) begin miscompares++; $display("FAIL midrst_drp: got busy=%b den=%b daddr=%h want 0/0/00", busy, bus.xadc_den, bus.xadc_daddr); end
        vectors++; if (bus.m_axis_tdata !== '0 || bus.m_axis_tvalid !== 1'b0) begin miscompares++; $display("FAIL midrst_stream: got %h/%b want 0/0", bus.m_axis_tdata, bus.m_axis_tvalid); end
        vectors++; if (overrun_count !== 16'h0 || timeout_err !== 1'b0) begin miscompares++; $display("FAIL midrst_status: got ovr=%0d terr=%b want 0/0", overrun_count, timeout_err); end
        tick();
        rst_n = 1'b1;
        repeat (30) tick();
        vectors++; if (beat_q.size() != 0 || busy !== 1'b0) begin miscompares++; $display("FAIL midrst_stale_drdy: got beats=%0d busy=%b want 0/0", beat_q.size(), busy); end
        vectors++; if (den_addr_q.size() != 1) begin miscompares++; $display("FAIL midrst_den_count: got %0d want 1", den_addr_q.size()); end

        clear_logs();
        resp_k = 3; resp_d0 = 16'h7777; resp_d1 = 16'h8888;
        pulse_eos(t);
        wait_beats(1, 50, ok);
        vectors++;
        if (den_addr_q.size() != 2 || den_addr_q[0] !== VAUX4 || den_addr_q[1] !== VAUX12) begin miscompares++; $display("FAIL midrst_clean_order: got %0d den want 14,1c", den_addr_q.size()); end
        vectors++;
        if (beat_q.size() != 1 || beat_q[0][RES_W-1:0] !== 32'h8888_7777) begin miscompares++; $display("FAIL midrst_clean_tdata: got %h want 88887777", bus.m_axis_tdata[RES_W-1:0]); end
    endtask

`ifdef XADC_DRP_SEQ_TIMESTAMP_EN
    task automatic test_timestamp();
        int t0, t1; bit ok; logic [31:0] ts0, ts1;
        clear_logs();
        pulse_eos(t0);
        repeat (511) tick();
        pulse_eos(t1);
        wait_beats(2, 60, ok);
        vectors++;
        if (beat_q.size() != 2) begin miscompares++; $display("FAIL timestamp_beats: got %0d want 2", beat_q.size()); end
        else begin
            ts0 = beat_q[0][OUT_W-1 -: 32];
            ts1 = beat_q[1][OUT_W-1 -: 32];
            if (ts1 - ts0 !== 32'd512) begin miscompares++; $display("FAIL timestamp_delta: got %0d want 512", ts1 - ts0); end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_decimation();
        test_timeout();
        test_overrun();
        test_reset_mid_sweep();
`ifdef XADC_DRP_SEQ_TIMESTAMP_EN
        test_timestamp();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
